// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter: owner tags, access sizes, default depth.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sram_like_arbiter_pkg;

    // Default number of accepted-but-unanswered requests (power of two, >= 2).
    localparam int OUTSTANDING_DEF = 4;

    // Owner tag stored per accepted request; 1 marks the data master.
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Access size encodings on the sram-like port.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Request fields presented to the slave, muxed from the granted master.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order FIFO of 1-bit owner tags, one entry per accepted memory request.
// Latency: registered state; a push becomes visible at head no earlier than next cycle.
// Backpressure: exposes full/empty; caller never pushes when full nor pops when empty.
//
// Ports: clk/reset (sync, active-high); push/push_dat write a tag; pop retires head;
//        full/empty status; head is the oldest outstanding owner tag.
module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_dat,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leave occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the fetch master and the data master.
// Latency: zero-cycle request path and zero-cycle response steering.
// Backpressure: stalls masters via addr_ok; holds a presented request until the slave
//               accepts it; stops issuing while OUTSTANDING requests are unanswered.
//
// Ports: clk/reset (sync, active-high); inst_* fetch master (read-only, word);
//        data_* load/store master; mem_* request/response toward the slave;
//        proto_err sticky flag for a response arriving with nothing outstanding.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEF
) (
    input  logic        clk,
    input  logic        reset,
    // fetch master
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // slave port
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        proto_err
);

    logic     grant;
    logic     grant_req;
    logic     lock_valid;
    logic     lock_owner;
    logic     accept;
    logic     pop;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_head;
    mem_req_t inst_fields;
    mem_req_t data_fields;
    mem_req_t req_fields;

    // A stalled request keeps its owner so the slave never sees the request change
    // before acceptance; otherwise data has priority over fetch.
    always_comb begin
        if (lock_valid) begin
            grant = lock_owner;
        end else if (data_req) begin
            grant = OWN_DATA;
        end else begin
            grant = OWN_INST;
        end
    end

    assign grant_req = (grant == OWN_DATA) ? data_req : inst_req;

    assign inst_fields = '{wr: 1'b0, size: SZ_WORD, addr: inst_addr, wdata: 32'h0};
    assign data_fields = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
    assign req_fields  = (grant == OWN_DATA) ? data_fields : inst_fields;

    assign mem_req   = grant_req & ~fifo_full & ~reset;
    assign mem_wr    = req_fields.wr;
    assign mem_size  = req_fields.size;
    assign mem_addr  = req_fields.addr;
    assign mem_wdata = req_fields.wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (grant == OWN_INST);
    assign data_addr_ok = accept & (grant == OWN_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_owner <= OWN_INST;
        end else if (mem_req && !mem_addr_ok) begin
            lock_valid <= 1'b1;
            lock_owner <= grant;
        end else if (mem_addr_ok) begin
            lock_valid <= 1'b0;
        end
    end

    // Responses return in order, so the oldest owner tag names the destination.
    assign pop          = mem_data_ok & ~fifo_empty & ~reset;
    assign inst_data_ok = pop & (fifo_head == OWN_INST);
    assign data_data_ok = pop & (fifo_head == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // An orphan response is dropped and flagged until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (mem_data_ok && fifo_empty) begin
            proto_err <= 1'b1;
        end
    end

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_dat (grant),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: the bench plays both masters and the slave.
// Expected responses are queued when the slave response is driven; a monitor pops
// and compares whenever either data_ok pulses.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        proto_err;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .proto_err    (proto_err)
    );

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        chk(name, 32'(got), 32'(exp));
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = SZ_WORD;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic drive_inst(input logic [31:0] addr);
        inst_req  = 1'b1;
        inst_addr = addr;
    endtask

    task automatic drive_data(input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wdata;
    endtask

    // Slave returns a response this cycle; the expected destination is hand-computed.
    task automatic respond(input logic owner, input logic [31:0] rdata);
        exp_t e;
        e.owner = owner;
        e.rdata = rdata;
        exp_q.push_back(e);
        mem_data_ok = 1'b1;
        mem_rdata   = rdata;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (inst_data_ok || data_data_ok) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_rsp: inst_data_ok=%b data_data_ok=%b, required no response",
                         inst_data_ok, data_data_ok);
            end else begin
                mon_e = exp_q.pop_front();
                chkb("rsp_data_ok", data_data_ok, mon_e.owner);
                chkb("rsp_inst_ok", inst_data_ok, !mon_e.owner);
                chk("rsp_rdata", mon_e.owner ? data_rdata : inst_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every input active: all handshake outputs must stay low.
        idle();
        reset       = 1'b1;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        sample();
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chkb("rst_data_addr_ok", data_addr_ok, 1'b0);
        chkb("rst_inst_data_ok", inst_data_ok, 1'b0);
        chkb("rst_data_data_ok", data_data_ok, 1'b0);
        next(); reset = 1'b0;
        sample();
        chkb("rst_proto_err", proto_err, 1'b0);
        chkb("idle_mem_req", mem_req, 1'b0);

        // Single fetch, response two cycles after acceptance.
        next(); drive_inst(32'hBFC0_0000); mem_addr_ok = 1'b1;
        sample();
        chkb("t1_mem_req", mem_req, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
        chkb("t1_mem_wr", mem_wr, 1'b0);
        chk("t1_mem_size", 32'(mem_size), 32'(SZ_WORD));
        chkb("t1_inst_addr_ok", inst_addr_ok, 1'b1);
        chkb("t1_data_addr_ok", data_addr_ok, 1'b0);
        next();
        sample();
        next(); respond(OWN_INST, 32'h3C08_0001);
        sample();
        chkb("t1_inst_data_ok", inst_data_ok, 1'b1);
        chkb("t1_data_data_ok", data_data_ok, 1'b0);

        // Simultaneous requests: data first, fetch next cycle, responses in order.
        next(); drive_inst(32'hBFC0_0004); drive_data(1'b0, SZ_WORD, 32'h8000_1000, 32'h0);
        mem_addr_ok = 1'b1;
        sample();
        chkb("t2_data_addr_ok", data_addr_ok, 1'b1);
        chkb("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        chk("t2_mem_addr_d", mem_addr, 32'h8000_1000);
        next(); drive_inst(32'hBFC0_0004); mem_addr_ok = 1'b1;
        sample();
        chkb("t2_inst_addr_ok2", inst_addr_ok, 1'b1);
        chk("t2_mem_addr_i", mem_addr, 32'hBFC0_0004);
        next(); respond(OWN_DATA, 32'h1111_1111);
        sample();
        next(); respond(OWN_INST, 32'h2222_2222);
        sample();

        // Slave stalls a fetch for three cycles while data starts requesting.
        next(); drive_inst(32'hBFC0_0008);
        sample();
        chkb("t3_mem_req", mem_req, 1'b1);
        chk("t3_mem_addr0", mem_addr, 32'hBFC0_0008);
        chkb("t3_inst_addr_ok0", inst_addr_ok, 1'b0);
        for (int c = 1; c < 3; c++) begin
            next(); drive_inst(32'hBFC0_0008); drive_data(1'b0, SZ_WORD, 32'h8000_2000, 32'h0);
            sample();
            chk("t3_mem_addr_held", mem_addr, 32'hBFC0_0008);
            chkb("t3_data_addr_ok_held", data_addr_ok, 1'b0);
        end
        next(); drive_inst(32'hBFC0_0008); drive_data(1'b0, SZ_WORD, 32'h8000_2000, 32'h0);
        mem_addr_ok = 1'b1;
        sample();
        chkb("t3_inst_addr_ok", inst_addr_ok, 1'b1);
        chkb("t3_data_addr_ok_lk", data_addr_ok, 1'b0);
        chk("t3_mem_addr_acc", mem_addr, 32'hBFC0_0008);
        next(); drive_data(1'b0, SZ_WORD, 32'h8000_2000, 32'h0); mem_addr_ok = 1'b1;
        sample();
        chkb("t3_data_addr_ok", data_addr_ok, 1'b1);
        chk("t3_mem_addr_d", mem_addr, 32'h8000_2000);
        next(); respond(OWN_INST, 32'h8C88_0000);
        sample();
        next(); respond(OWN_DATA, 32'h1234_5678);
        sample();

        // Fill all four slots, then a response frees one for the following cycle.
        for (int i = 0; i < 4; i++) begin
            next(); drive_inst(32'hBFC0_0100 + 32'(4 * i)); mem_addr_ok = 1'b1;
            sample();
            chkb("t4_fill_addr_ok", inst_addr_ok, 1'b1);
        end
        next(); drive_inst(32'hBFC0_0110); mem_addr_ok = 1'b1;
        sample();
        chkb("t4_full_mem_req", mem_req, 1'b0);
        chkb("t4_full_addr_ok", inst_addr_ok, 1'b0);
        next(); drive_inst(32'hBFC0_0110); mem_addr_ok = 1'b1; respond(OWN_INST, 32'h0000_00A0);
        sample();
        chkb("t4_popcyc_mem_req", mem_req, 1'b0);
        next(); drive_inst(32'hBFC0_0110); mem_addr_ok = 1'b1;
        sample();
        chkb("t4_resume_addr_ok", inst_addr_ok, 1'b1);
        next(); drive_inst(32'hBFC0_0114); mem_addr_ok = 1'b1;
        sample();
        chkb("t4_full_again", mem_req, 1'b0);
        for (int i = 1; i < 5; i++) begin
            next(); respond(OWN_INST, 32'h0000_00A0 + 32'(i));
            sample();
        end

        // Byte store interleaved with fetches; responses one cycle apart.
        next(); drive_inst(32'hBFC0_0200); mem_addr_ok = 1'b1;
        sample();
        chkb("t5_inst_addr_ok", inst_addr_ok, 1'b1);
        next(); drive_inst(32'hBFC0_0204);
        drive_data(1'b1, SZ_BYTE, 32'h8000_0003, 32'h0000_00AB); mem_addr_ok = 1'b1;
        sample();
        chkb("t5_data_addr_ok", data_addr_ok, 1'b1);
        chkb("t5_inst_blocked", inst_addr_ok, 1'b0);
        chkb("t5_mem_wr", mem_wr, 1'b1);
        chk("t5_mem_size", 32'(mem_size), 32'(SZ_BYTE));
        chk("t5_mem_addr", mem_addr, 32'h8000_0003);
        chk("t5_mem_wdata", mem_wdata, 32'h0000_00AB);
        next(); drive_inst(32'hBFC0_0204); mem_addr_ok = 1'b1; respond(OWN_INST, 32'h2402_0001);
        sample();
        chkb("t5_inst_addr_ok2", inst_addr_ok, 1'b1);
        chk("t5_inst_wdata", mem_wdata, 32'h0);
        next();
        sample();
        next(); respond(OWN_DATA, 32'h0);
        sample();
        next();
        sample();
        next(); respond(OWN_INST, 32'h2403_0002);
        sample();

        // Orphan response sets a sticky error and is not delivered.
        next(); mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        sample();
        chkb("t6_no_inst_ok", inst_data_ok, 1'b0);
        chkb("t6_no_data_ok", data_data_ok, 1'b0);
        next();
        sample();
        chkb("t6_proto_err_set", proto_err, 1'b1);
        next();
        sample();
        chkb("t6_proto_err_sticky", proto_err, 1'b1);
        // Leave a fetch outstanding, then reset: it must be forgotten.
        next(); drive_inst(32'hBFC0_0300); mem_addr_ok = 1'b1;
        sample();
        chkb("t6_pre_rst_accept", inst_addr_ok, 1'b1);
        next(); reset = 1'b1;
        sample();
        next(); reset = 1'b0;
        sample();
        chkb("t6_proto_err_clr", proto_err, 1'b0);
        next(); mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
        sample();
        chkb("t6_empty_no_inst_ok", inst_data_ok, 1'b0);
        chkb("t6_empty_no_data_ok", data_data_ok, 1'b0);
        next();
        sample();
        chkb("t6_empty_proto_err", proto_err, 1'b1);

        next();
        sample();
        chk("rsp_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
